// File: rtl/cache_pkg.sv
// cache_pkg: shared cache/memory types, DRAM model state encoding and default latency
package cache_pkg;
  typedef enum logic {
    LW = 1'b0,
    SW = 1'b1
  } lsu_ops;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } dram_state_t;
  localparam int DRAM_LATENCY = 4;
endpackage

// File: rtl/dram_model.sv
// dram_model: fixed-latency word-addressed DRAM with four-phase req/ready handshake
// Ports: clk, rst (sync, active-high); mem_req/lsu_operator/mem_addr/write_data_int request in;
// mem_ready response valid, dram_data_input read/echoed write data, busy while not IDLE.
module dram_model
  import cache_pkg::*;
#(
  parameter int DATA    = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = DRAM_LATENCY
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_req,
  input  lsu_ops          lsu_operator,
  input  logic [31:0]     mem_addr,
  input  logic [DATA-1:0] write_data_int,
  output logic            mem_ready,
  output logic [DATA-1:0] dram_data_input,
  output logic            busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  dram_state_t state, state_n;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   idx;
  lsu_ops          op;
  logic [DATA-1:0] wdata;
  logic [DATA-1:0] rdata;
  logic [DATA-1:0] mem [DEPTH] = '{default: '0};
  logic            fire;
  logic            unused_addr;
  assign unused_addr = ^{mem_addr[31:AW+2], mem_addr[1:0]};
  // the access happens on the last WAIT edge, the same edge that enters READY
  assign fire = state == WAIT && cnt == '0;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (mem_req ? WAIT : IDLE)
            : state == WAIT ? (fire ? READY : WAIT)
            : (mem_req ? READY : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rdata <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && mem_req) cnt <= CW'(LATENCY - 1);
      else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
      if (fire) rdata <= op == SW ? wdata : mem[idx];
    end
  end
  // captured request fields need no reset: they are only consumed after a fresh capture
  always_ff @(posedge clk) begin
    if (state == IDLE && mem_req) begin
      idx   <= mem_addr[AW+1:2];
      op    <= lsu_operator;
      wdata <= write_data_int;
    end
  end
  // memory contents deliberately survive reset; a reset edge cancels a pending write
  always_ff @(posedge clk) begin
    if (!rst && fire && op == SW) mem[idx] <= wdata;
  end
  assign mem_ready       = state == READY;
  assign busy            = state != IDLE;
  assign dram_data_input = rdata;
endmodule

// File: tb/tb_dram_model.sv
// tb_dram_model: directed self-checking bench for dram_model at LATENCY 4 and LATENCY 1
module tb_dram_model;
  import cache_pkg::*;
  logic        clk = 0;
  logic        rst = 1;
  logic        req0 = 0, req1 = 0;
  lsu_ops      op = LW;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic        rdy0, rdy1, busy0, busy1;
  logic [31:0] dout0, dout1;
  int          errors = 0;
  int          checks = 0;

  dram_model #(.DATA(32), .DEPTH(256), .LATENCY(4)) dut0 (
    .clk(clk), .rst(rst), .mem_req(req0), .lsu_operator(op), .mem_addr(addr),
    .write_data_int(wd), .mem_ready(rdy0), .dram_data_input(dout0), .busy(busy0)
  );
  dram_model #(.DATA(32), .DEPTH(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_req(req1), .lsu_operator(op), .mem_addr(addr),
    .write_data_int(wd), .mem_ready(rdy1), .dram_data_input(dout1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // raise req, wait for ready (bounded); lat = edges after acceptance until ready
  task automatic do_txn(input bit sel, input lsu_ops o, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] q, output int lat);
    op = o; addr = a; wd = d;
    if (sel) req1 = 1; else req0 = 1;
    step();
    lat = 0;
    while (((sel ? rdy1 : rdy0) !== 1'b1) && lat < 20) begin
      step();
      lat++;
    end
    q = sel ? dout1 : dout0;
  endtask

  task automatic end_txn();
    req0 = 0; req1 = 0;
    step();
  endtask

  task automatic test_reset();
    rst = 1;
    step(); step();
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", rdy0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    checks++; if (dout0 !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", dout0); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy_l1: got %b expected 0", busy1); end
    rst = 0;
    step();
  endtask

  task automatic test_write_timing();
    op = SW; addr = 32'h10; wd = 32'hDEAD_BEEF; req0 = 1;
    step();
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL wr_busy_k1: got %b expected 1", busy0); end
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL wr_ready_k1: got %b expected 0", rdy0); end
    step(); step(); step();
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL wr_ready_k3: got %b expected 0", rdy0); end
    step();
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL wr_ready_k4: got %b expected 1", rdy0); end
    checks++; if (dout0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_echo: got %h expected deadbeef", dout0); end
    end_txn();
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL wr_ready_drop: got %b expected 0", rdy0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL wr_busy_drop: got %b expected 0", busy0); end
  endtask

  task automatic test_read_hold();
    logic [31:0] q;
    int lat;
    do_txn(0, LW, 32'h10, 32'h0, q, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rd_latency: got %0d expected 4", lat); end
    checks++; if (q !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", q); end
    step(); step();
    checks++; if (rdy0 !== 1'b1 || dout0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_hold: got rdy=%b data=%h expected rdy=1 data=deadbeef", rdy0, dout0); end
    end_txn();
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL rd_ready_drop: got %b expected 0", rdy0); end
    checks++; if (dout0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data_after: got %h expected deadbeef", dout0); end
  endtask

  task automatic test_wrap();
    logic [31:0] q;
    int lat;
    do_txn(0, SW, 32'h404, 32'h1234_5678, q, lat); end_txn();
    do_txn(0, LW, 32'h4, 32'h0, q, lat); end_txn();
    checks++; if (q !== 32'h1234_5678) begin errors++; $display("FAIL wrap_read: got %h expected 12345678", q); end
    do_txn(0, LW, 32'h7, 32'h0, q, lat); end_txn();
    checks++; if (q !== 32'h1234_5678) begin errors++; $display("FAIL byte_bits_ignored: got %h expected 12345678", q); end
  endtask

  task automatic test_latency1();
    logic [31:0] q;
    int lat;
    do_txn(1, LW, 32'h20, 32'h0, q, lat); end_txn();
    checks++; if (lat !== 1) begin errors++; $display("FAIL l1_latency: got %0d expected 1", lat); end
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL l1_unwritten: got %h expected 0", q); end
    do_txn(1, SW, 32'h24, 32'hCAFE_0001, q, lat); end_txn();
    do_txn(1, LW, 32'h24, 32'h0, q, lat); end_txn();
    checks++; if (q !== 32'hCAFE_0001) begin errors++; $display("FAIL l1_readback: got %h expected cafe0001", q); end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] q;
    int lat;
    logic seen = 0;
    op = SW; addr = 32'h30; wd = 32'hAAAA_5555; req0 = 1;
    step();
    step();
    rst = 1;
    step();
    checks++; if (busy0 !== 1'b0 || rdy0 !== 1'b0 || dout0 !== 32'h0) begin errors++; $display("FAIL rst_wait_state: got busy=%b rdy=%b data=%h expected 0 0 0", busy0, rdy0, dout0); end
    rst = 0; req0 = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rdy0) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_wait_no_ready: got %b expected 0", seen); end
    do_txn(0, LW, 32'h30, 32'h0, q, lat); end_txn();
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL rst_wait_no_write: got %h expected 0", q); end
    do_txn(0, LW, 32'h10, 32'h0, q, lat); end_txn();
    checks++; if (q !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rst_keeps_array: got %h expected deadbeef", q); end
  endtask

  task automatic test_ignore_in_wait();
    logic [31:0] q;
    int lat;
    op = SW; addr = 32'h50; wd = 32'h2222_2222; req0 = 1;
    step();
    addr = 32'h40; wd = 32'h1111_1111; op = LW;
    lat = 0;
    while (rdy0 !== 1'b1 && lat < 20) begin step(); lat++; end
    checks++; if (lat !== 4 || dout0 !== 32'h2222_2222) begin errors++; $display("FAIL ign_resp: got lat=%0d data=%h expected 4 22222222", lat, dout0); end
    end_txn();
    do_txn(0, LW, 32'h50, 32'h0, q, lat); end_txn();
    checks++; if (q !== 32'h2222_2222) begin errors++; $display("FAIL ign_read50: got %h expected 22222222", q); end
    do_txn(0, LW, 32'h40, 32'h0, q, lat); end_txn();
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL ign_read40: got %h expected 0", q); end
  endtask

  task automatic test_drop_in_wait();
    logic [31:0] q;
    int lat;
    op = SW; addr = 32'h60; wd = 32'h3333_3333; req0 = 1;
    step();
    req0 = 0;
    lat = 0;
    while (rdy0 !== 1'b1 && lat < 20) begin step(); lat++; end
    checks++; if (lat !== 4) begin errors++; $display("FAIL drop_ready: got lat=%0d expected 4", lat); end
    step();
    checks++; if (rdy0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL drop_one_cycle: got rdy=%b busy=%b expected 0 0", rdy0, busy0); end
    do_txn(0, LW, 32'h60, 32'h0, q, lat); end_txn();
    checks++; if (q !== 32'h3333_3333) begin errors++; $display("FAIL drop_committed: got %h expected 33333333", q); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q;
    int lat;
    do_txn(0, SW, 32'h70, 32'h7777_0000, q, lat);
    req0 = 0;
    step();
    req0 = 1; op = LW; addr = 32'h70;
    step();
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", busy0); end
    lat = 0;
    while (rdy0 !== 1'b1 && lat < 20) begin step(); lat++; end
    checks++; if (lat !== 4 || dout0 !== 32'h7777_0000) begin errors++; $display("FAIL b2b_read: got lat=%0d data=%h expected 4 77770000", lat, dout0); end
    end_txn();
  endtask

  initial begin
    test_reset();
    test_write_timing();
    test_read_hold();
    test_wrap();
    test_latency1();
    test_reset_in_wait();
    test_ignore_in_wait();
    test_drop_in_wait();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
